// File: rtl/bhb_update_sched.sv
// Branch history buffer write sequencer: queues EX resolutions, drains them to the BHB,
// raises front-end redirects on mispredicts and walks the table for full invalidates.
//
// state | meaning
// IDLE  | normal operation, FIFO accepts and drains
// INVAL | invalidate walk, one entry strobed per cycle
// DONE  | walk finished, inv_done pulse
module bhb_update_sched #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ex_valid,
    input  logic [WIDTH-1:0]         ex_pc,
    input  logic [WIDTH-1:0]         ex_target,
    input  logic                     ex_taken,
    input  logic                     ex_pred_taken,
    input  logic [WIDTH-1:0]         ex_pred_addr,
    output logic                     ex_ready,
    output logic                     upd_valid,
    output logic [WIDTH-1:0]         upd_pc,
    output logic [WIDTH-1:0]         upd_target,
    output logic                     upd_taken,
    input  logic                     upd_ready,
    input  logic                     inv_req,
    output logic                     inv_busy,
    output logic                     inv_we,
    output logic [$clog2(SIZE)-1:0]  inv_idx,
    output logic                     inv_done,
    output logic                     redirect_valid,
    output logic [WIDTH-1:0]         redirect_pc,
    output logic [31:0]              mispredict_cnt,
    output logic [15:0]              drop_cnt
);
    localparam int IDXW = $clog2(SIZE);
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, INVAL = 2'd1, DONE = 2'd2} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDXW-1:0]   r_idx;
    logic              r_live;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW-1:0]     r_wr_ptr;
    logic [CW-1:0]     r_cnt;
    logic [WIDTH-1:0]  r_pc_mem  [DEPTH];
    logic [WIDTH-1:0]  r_tgt_mem [DEPTH];
    logic [DEPTH-1:0]  r_tkn_mem;
    logic              r_redir_v;
    logic [WIDTH-1:0]  r_redir_pc;
    logic [31:0]       r_mis_cnt;
    logic [15:0]       r_drop_cnt;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;
    logic              w_mis;
    logic              w_clear;

    assign w_full  = (r_cnt == CW'(DEPTH));
    assign w_empty = (r_cnt == '0);
    assign w_push  = ex_valid & ex_ready;
    assign w_pop   = upd_valid & upd_ready;
    assign w_drop  = ex_valid & ~ex_ready;
    assign w_clear = (r_state == IDLE) & inv_req;
    assign w_mis   = (ex_taken != ex_pred_taken) |
                     (ex_taken & ex_pred_taken & (ex_target != ex_pred_addr));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (inv_req) w_state_nxt = INVAL;
            INVAL:   if (r_idx == IDXW'(SIZE - 1)) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ex_ready  = r_live & ~w_full & (r_state == IDLE);
        upd_valid = ~w_empty & (r_state == IDLE);
        inv_we    = (r_state == INVAL);
        inv_done  = (r_state == DONE);
        inv_busy  = (r_state == INVAL) | (r_state == DONE);
    end

    // r_live keeps ex_ready low through reset and releases it on the first clock afterwards
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_live <= 1'b0;
            r_idx  <= '0;
        end else begin
            r_live <= 1'b1;
            if (r_state == INVAL) r_idx <= r_idx + IDXW'(1);
            else if (r_state == IDLE) r_idx <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_cnt     <= '0;
            r_tkn_mem <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_mem[i]  <= '0;
                r_tgt_mem[i] <= '0;
            end
        end else if (w_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_pc_mem[r_wr_ptr]  <= ex_pc;
                r_tgt_mem[r_wr_ptr] <= ex_target;
                r_tkn_mem[r_wr_ptr] <= ex_taken;
                r_wr_ptr            <= r_wr_ptr + PW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_redir_v  <= 1'b0;
            r_redir_pc <= '0;
            r_mis_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_redir_v <= ex_valid & w_mis;
            if (ex_valid & w_mis) begin
                r_redir_pc <= ex_taken ? ex_target : ex_pc + WIDTH'(4);
                if (r_mis_cnt != '1) r_mis_cnt <= r_mis_cnt + 32'd1;
            end
            if (w_drop && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign upd_pc         = r_pc_mem[r_rd_ptr];
    assign upd_target     = r_tgt_mem[r_rd_ptr];
    assign upd_taken      = r_tkn_mem[r_rd_ptr];
    assign inv_idx        = r_idx;
    assign redirect_valid = r_redir_v;
    assign redirect_pc    = r_redir_pc;
    assign mispredict_cnt = r_mis_cnt;
    assign drop_cnt       = r_drop_cnt;
endmodule

// File: tb/tb_bhb_update_sched.sv
// Directed bench for bhb_update_sched: vector table for queueing/mispredicts,
// hand sequences for push+pop streaming, invalidate walk and mid-walk reset.
module tb_bhb_update_sched;
    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_target, ex_pred_addr;
    logic        ex_taken, ex_pred_taken;
    logic        ex_ready, upd_valid, upd_taken, upd_ready;
    logic [31:0] upd_pc, upd_target;
    logic        inv_req, inv_busy, inv_we, inv_done;
    logic [2:0]  inv_idx;
    logic        redirect_valid;
    logic [31:0] redirect_pc, mispredict_cnt;
    logic [15:0] drop_cnt;

    int total = 0;
    int bad   = 0;

    bhb_update_sched #(.WIDTH(32), .SIZE(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_target(ex_target),
        .ex_taken(ex_taken), .ex_pred_taken(ex_pred_taken), .ex_pred_addr(ex_pred_addr),
        .ex_ready(ex_ready), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_target(upd_target), .upd_taken(upd_taken), .upd_ready(upd_ready),
        .inv_req(inv_req), .inv_busy(inv_busy), .inv_we(inv_we), .inv_idx(inv_idx),
        .inv_done(inv_done), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mispredict_cnt(mispredict_cnt), .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] pc, tgt;
        logic        tk, ptk;
        logic [31:0] pa;
        logic        urdy;
        logic        e_rdy, e_uv;
        logic [31:0] e_upc;
        logic        e_rv;
        logic [31:0] e_rpc, e_mis;
        logic [15:0] e_drop;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(logic v, logic [31:0] pc, logic [31:0] tgt, logic tk, logic ptk,
                                logic [31:0] pa, logic urdy, logic e_rdy, logic e_uv,
                                logic [31:0] e_upc, logic e_rv, logic [31:0] e_rpc,
                                logic [31:0] e_mis, logic [15:0] e_drop);
        vec_t r;
        r.v = v; r.pc = pc; r.tgt = tgt; r.tk = tk; r.ptk = ptk; r.pa = pa; r.urdy = urdy;
        r.e_rdy = e_rdy; r.e_uv = e_uv; r.e_upc = e_upc; r.e_rv = e_rv; r.e_rpc = e_rpc;
        r.e_mis = e_mis; r.e_drop = e_drop;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                         input logic tk, input logic ptk, input logic [31:0] pa,
                         input logic urdy);
        ex_valid = v; ex_pc = pc; ex_target = tgt; ex_taken = tk;
        ex_pred_taken = ptk; ex_pred_addr = pa; upd_ready = urdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] q[$];
    int          n_done;

    initial begin
        rst = 1'b0; inv_req = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);

        tbl[0]  = mk(1, 32'h10, 32'h80, 1, 1, 32'h80, 0,  1, 1, 32'h10, 0, 0, 0, 0);
        tbl[1]  = mk(1, 32'h20, 32'h90, 1, 1, 32'h90, 0,  1, 1, 32'h10, 0, 0, 0, 0);
        tbl[2]  = mk(1, 32'h30, 32'hA0, 1, 1, 32'hA0, 0,  1, 1, 32'h10, 0, 0, 0, 0);
        tbl[3]  = mk(1, 32'h40, 32'hB0, 1, 1, 32'hB0, 0,  0, 1, 32'h10, 0, 0, 0, 0);
        tbl[4]  = mk(1, 32'h50, 32'hC0, 1, 1, 32'hC0, 0,  0, 1, 32'h10, 0, 0, 0, 1);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 1,                 1, 1, 32'h20, 0, 0, 0, 1);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 1,                 1, 1, 32'h30, 0, 0, 0, 1);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 1,                 1, 1, 32'h40, 0, 0, 0, 1);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 1,                 1, 0, 0, 0, 0, 0, 1);
        tbl[9]  = mk(1, 32'h100, 32'h180, 0, 1, 0, 1,     1, 1, 32'h100, 1, 32'h104, 1, 1);
        tbl[10] = mk(1, 32'h120, 32'h200, 1, 1, 32'h240, 1, 1, 1, 32'h120, 1, 32'h200, 2, 1);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 1,                 1, 0, 0, 0, 0, 2, 1);
        tbl[12] = mk(1, 32'h300, 32'h400, 1, 0, 0, 0,     1, 1, 32'h300, 1, 32'h400, 3, 1);
        tbl[13] = mk(1, 32'hFFFFFFFC, 32'h10, 0, 1, 0, 1, 1, 1, 32'hFFFFFFFC, 1, 32'h0, 4, 1);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 1,                 1, 0, 0, 0, 0, 4, 1);
        tbl[15] = mk(1, 32'h500, 32'h600, 0, 0, 32'h123, 0, 1, 1, 32'h500, 0, 0, 4, 1);
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 1,                 1, 0, 0, 0, 0, 4, 1);

        // reset held for 5 cycles
        repeat (5) @(posedge clk);
        #1;
        chk("rst_ex_ready", {31'd0, ex_ready}, 0);
        chk("rst_inv_busy", {31'd0, inv_busy}, 0);
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("rel_ex_ready", {31'd0, ex_ready}, 1);
        chk("rel_upd_valid", {31'd0, upd_valid}, 0);
        chk("rel_mis_cnt", mispredict_cnt, 0);
        chk("rel_drop_cnt", {16'd0, drop_cnt}, 0);
        chk("rel_inv_busy", {31'd0, inv_busy}, 0);
        chk("rel_redirect", {31'd0, redirect_valid}, 0);

        // table: fill/drain, drop, mispredicts
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].v, tbl[i].pc, tbl[i].tgt, tbl[i].tk, tbl[i].ptk, tbl[i].pa, tbl[i].urdy);
            step();
            chk($sformatf("v%0d_ex_ready", i), {31'd0, ex_ready}, {31'd0, tbl[i].e_rdy});
            chk($sformatf("v%0d_upd_valid", i), {31'd0, upd_valid}, {31'd0, tbl[i].e_uv});
            if (tbl[i].e_uv) chk($sformatf("v%0d_upd_pc", i), upd_pc, tbl[i].e_upc);
            chk($sformatf("v%0d_redir_v", i), {31'd0, redirect_valid}, {31'd0, tbl[i].e_rv});
            if (tbl[i].e_rv) chk($sformatf("v%0d_redir_pc", i), redirect_pc, tbl[i].e_rpc);
            chk($sformatf("v%0d_mis_cnt", i), mispredict_cnt, tbl[i].e_mis);
            chk($sformatf("v%0d_drop_cnt", i), {16'd0, drop_cnt}, {16'd0, tbl[i].e_drop});
        end

        // streaming push+pop at occupancy 2
        for (int i = 0; i < 2; i++) begin
            drive(1, 32'h1000 + 32'(i * 4), 32'h1040 + 32'(i * 4), 1, 1,
                  32'h1040 + 32'(i * 4), 0);
            q.push_back(32'h1000 + 32'(i * 4));
            step();
        end
        for (int i = 0; i < 10; i++) begin
            drive(1, 32'h2000 + 32'(i * 4), 32'h2040 + 32'(i * 4), 1, 1,
                  32'h2040 + 32'(i * 4), 1);
            step();
            void'(q.pop_front());
            q.push_back(32'h2000 + 32'(i * 4));
            chk($sformatf("pp%0d_upd_pc", i), upd_pc, q[0]);
            chk($sformatf("pp%0d_upd_tgt", i), upd_target, q[0] + 32'h40);
            chk($sformatf("pp%0d_ex_ready", i), {31'd0, ex_ready}, 1);
            chk($sformatf("pp%0d_upd_valid", i), {31'd0, upd_valid}, 1);
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        step();
        void'(q.pop_front());
        chk("pp_drain1_pc", upd_pc, q[0]);
        step();
        chk("pp_drain2_uv", {31'd0, upd_valid}, 0);

        // invalidate walk with 3 queued entries and EX traffic during the walk
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h3000 + 32'(i * 4), 32'h3100, 1, 1, 32'h3100, 0);
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        inv_req = 1'b1;
        step();
        inv_req = 1'b0;
        drive(1, 32'h4000, 32'h4100, 1, 1, 32'h4100, 1);
        chk("inv_we_0", {31'd0, inv_we}, 1);
        chk("inv_idx_0", {29'd0, inv_idx}, 0);
        chk("inv_upd_valid", {31'd0, upd_valid}, 0);
        chk("inv_ex_ready", {31'd0, ex_ready}, 0);
        for (int k = 1; k < 8; k++) begin
            step();
            chk($sformatf("inv_we_%0d", k), {31'd0, inv_we}, 1);
            chk($sformatf("inv_idx_%0d", k), {29'd0, inv_idx}, 32'(k));
            chk($sformatf("inv_busy_%0d", k), {31'd0, inv_busy}, 1);
            chk($sformatf("inv_done_%0d", k), {31'd0, inv_done}, 0);
        end
        step();
        chk("inv_done_pulse", {31'd0, inv_done}, 1);
        chk("inv_done_we", {31'd0, inv_we}, 0);
        chk("inv_done_busy", {31'd0, inv_busy}, 1);
        step();
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("inv_end_busy", {31'd0, inv_busy}, 0);
        chk("inv_end_done", {31'd0, inv_done}, 0);
        chk("inv_fifo_empty", {31'd0, upd_valid}, 0);
        chk("inv_end_ready", {31'd0, ex_ready}, 1);
        chk("inv_drop_cnt", {16'd0, drop_cnt}, 10);
        chk("inv_mis_cnt", mispredict_cnt, 4);

        // asynchronous reset mid-walk at inv_idx=3
        inv_req = 1'b1;
        step();
        inv_req = 1'b0;
        repeat (3) step();
        chk("mid_idx", {29'd0, inv_idx}, 3);
        #2;
        rst = 1'b0;
        #1;
        chk("async_we", {31'd0, inv_we}, 0);
        chk("async_busy", {31'd0, inv_busy}, 0);
        chk("async_ex_ready", {31'd0, ex_ready}, 0);
        chk("async_mis_cnt", mispredict_cnt, 0);
        chk("async_drop_cnt", {16'd0, drop_cnt}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (inv_done || inv_busy) n_done++;
        end
        chk("post_rst_no_walk", 32'(n_done), 0);
        chk("post_rst_ready", {31'd0, ex_ready}, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
